// File: rtl/xilinx_bram_rr_arbiter.sv
// Round-robin arbiter sharing one port of a single-clock true-dual-port BRAM between NUM_REQ requesters.
// An optional post-reset sequencer zero-fills the whole memory before any requester is served.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_CLEAR | writing zero to every address, requesters are held off
// ST_RUN   | round-robin arbitration of requester commands
module xilinx_bram_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 36,
    parameter int WE_WIDTH       = (DATA_WIDTH + 7) / 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*WE_WIDTH-1:0]      req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             busy,
    output logic                             bram_en,
    output logic [WE_WIDTH-1:0]              bram_we,
    output logic [14:0]                      bram_addr,
    output logic [DATA_WIDTH-1:0]            bram_di,
    input  logic [DATA_WIDTH-1:0]            bram_do
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_cnt;
    logic [PTR_W-1:0]       ptr_q;
    logic [PTR_W-1:0]       grant_idx;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     rd_tag;
    logic                   found;
    int                     idx;
    logic [NUM_REQ-1:0]     tag_pipe [READ_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (found) begin
                ptr_q <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        bram_en   = 1'b0;
        bram_we   = '0;
        bram_addr = '0;
        bram_di   = '0;
        if (state_q == ST_CLEAR) begin
            bram_en   = 1'b1;
            bram_we   = '1;
            bram_addr = 15'(clr_cnt);
            if (clr_cnt == '1) begin
                state_d = ST_RUN;
            end
        end else begin
            // first valid requester at or after the pointer, wrapping around
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr_q) + k) % NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = PTR_W'(idx);
                    bram_en    = 1'b1;
                    bram_we    = req_we[idx*WE_WIDTH +: WE_WIDTH];
                    bram_addr  = 15'(req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH]);
                    bram_di    = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        // outputs are quiet while reset is asserted, whatever the reset state
        if (!rst_n) begin
            found   = 1'b0;
            grant   = '0;
            bram_en = 1'b0;
            bram_we = '0;
        end
    end

    assign rd_tag = (bram_we == '0) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= rd_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign req_ready = grant;
    assign rsp_valid = tag_pipe[READ_LATENCY-1];
    assign rsp_rdata = bram_do;
    assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_xilinx_bram_rr_arbiter.sv
// Bench for xilinx_bram_rr_arbiter: two instances (latency 1 with clear, latency 2 without)
// against bench-side BRAM models and a queue-based reference model of arbitration and memory.
module tb_xilinx_bram_rr_arbiter;

    localparam int NR = 4;
    localparam int AW = 4;
    localparam int DW = 36;
    localparam int WW = 5;

    logic clk;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // instance A: READ_LATENCY=1, CLEAR_ON_RESET=1
    logic            a_rst_n;
    logic [NR-1:0]   a_valid, a_ready, a_rsp;
    logic [NR*WW-1:0] a_we;
    logic [NR*AW-1:0] a_addr;
    logic [NR*DW-1:0] a_wdata;
    logic [DW-1:0]   a_rdata, a_di, a_do;
    logic            a_busy, a_en;
    logic [WW-1:0]   a_bwe;
    logic [14:0]     a_baddr;

    // instance B: READ_LATENCY=2, CLEAR_ON_RESET=0
    logic            b_rst_n;
    logic [NR-1:0]   b_valid, b_ready, b_rsp;
    logic [NR*WW-1:0] b_we;
    logic [NR*AW-1:0] b_addr;
    logic [NR*DW-1:0] b_wdata;
    logic [DW-1:0]   b_rdata, b_di, b_do, b_do1;
    logic            b_busy, b_en;
    logic [WW-1:0]   b_bwe;
    logic [14:0]     b_baddr;

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];

    // reference model state
    typedef struct {
        int            due;
        logic [NR-1:0] tag;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [16];
    int            ref_ptr;
    logic          pend_v    [NR];
    logic [WW-1:0] pend_we   [NR];
    logic [AW-1:0] pend_addr [NR];
    logic [DW-1:0] pend_data [NR];

    xilinx_bram_rr_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp), .rsp_rdata(a_rdata), .busy(a_busy),
        .bram_en(a_en), .bram_we(a_bwe), .bram_addr(a_baddr), .bram_di(a_di), .bram_do(a_do)
    );

    xilinx_bram_rr_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
        .READ_LATENCY(2), .CLEAR_ON_RESET(0)
    ) dut2 (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp), .rsp_rdata(b_rdata), .busy(b_busy),
        .bram_en(b_en), .bram_we(b_bwe), .bram_addr(b_baddr), .bram_di(b_di), .bram_do(b_do)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [WW-1:0] we);
        logic [DW-1:0] r;
        for (int k = 0; k < DW; k++) r[k] = we[k/8] ? new_w[k] : old_w[k];
        return r;
    endfunction

    // BRAM port models (read-first); B has the output register enabled
    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 36'({$urandom, $urandom});
            mem_b[i] = 36'({$urandom, $urandom});
        end
        a_do = '0; b_do = '0; b_do1 = '0;
        forever begin
            @(posedge clk);
            if (a_en) begin
                a_do <= mem_a[a_baddr[3:0]];
                mem_a[a_baddr[3:0]] <= merge(mem_a[a_baddr[3:0]], a_di, a_bwe);
            end
            b_do <= b_do1;
            if (b_en) begin
                b_do1 <= mem_b[b_baddr[3:0]];
                mem_b[b_baddr[3:0]] <= merge(mem_b[b_baddr[3:0]], b_di, b_bwe);
            end
        end
    end

    task automatic drive_a(input int i, input logic v, input logic [WW-1:0] we,
                           input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_valid[i]          = v;
        a_we[i*WW +: WW]    = we;
        a_addr[i*AW +: AW]  = ad;
        a_wdata[i*DW +: DW] = d;
    endtask

    task automatic drive_b(input int i, input logic v, input logic [AW-1:0] ad);
        b_valid[i]          = v;
        b_we[i*WW +: WW]    = '0;
        b_addr[i*AW +: AW]  = ad;
        b_wdata[i*DW +: DW] = '0;
    endtask

    task automatic test_reset;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_we = '0; a_wdata = '0; b_we = '0; b_wdata = '0; b_addr = '0;
        for (int i = 0; i < NR; i++) drive_a(i, 1'b1, '0, AW'(i), '0);
        b_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (a_busy !== 1'b1) $display("FAIL rst_busy_a: got %b expected 1", a_busy); else n_pass++;
        n_checks++; if (a_ready !== 4'b0) $display("FAIL rst_ready_a: got %b expected 0000", a_ready); else n_pass++;
        n_checks++; if (a_rsp !== 4'b0) $display("FAIL rst_rsp_a: got %b expected 0000", a_rsp); else n_pass++;
        n_checks++; if (a_en !== 1'b0) $display("FAIL rst_en_a: got %b expected 0", a_en); else n_pass++;
        n_checks++; if (a_bwe !== 5'b0) $display("FAIL rst_we_a: got %h expected 00", a_bwe); else n_pass++;
        n_checks++; if (b_busy !== 1'b0) $display("FAIL rst_busy_b: got %b expected 0", b_busy); else n_pass++;
        n_checks++; if (b_ready !== 4'b0) $display("FAIL rst_ready_b: got %b expected 0000", b_ready); else n_pass++;
        n_checks++; if (b_en !== 1'b0) $display("FAIL rst_en_b: got %b expected 0", b_en); else n_pass++;
        b_valid = '0;
    endtask

    task automatic test_clear;
        @(negedge clk);
        a_rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (a_busy !== 1'b1) $display("FAIL clr_busy[%0d]: got %b expected 1", i, a_busy); else n_pass++;
            n_checks++; if (a_en !== 1'b1 || a_bwe !== 5'h1f) $display("FAIL clr_en_we[%0d]: got %b/%h expected 1/1f", i, a_en, a_bwe); else n_pass++;
            n_checks++; if (a_baddr !== 15'(i)) $display("FAIL clr_addr[%0d]: got %0d expected %0d", i, a_baddr, i); else n_pass++;
            n_checks++; if (a_di !== '0) $display("FAIL clr_di[%0d]: got %h expected 0", i, a_di); else n_pass++;
            n_checks++; if (a_ready !== 4'b0) $display("FAIL clr_ready[%0d]: got %b expected 0000", i, a_ready); else n_pass++;
            @(negedge clk);
            #1;
        end
        a_valid = '0;
        #1;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL clr_done_busy: got %b expected 0", a_busy); else n_pass++;
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < NR; i++) drive_a(i, 1'b1, '0, AW'(i), '0);
        for (int j = 0; j <= 6; j++) begin
            #1;
            if (j > 0) begin
                n_checks++; if (a_rsp !== 4'(1 << ((j-1) % NR))) $display("FAIL rr_rsp[%0d]: got %b expected %b", j, a_rsp, 4'(1 << ((j-1) % NR))); else n_pass++;
                n_checks++; if (a_rdata !== '0) $display("FAIL rr_rdata[%0d]: got %h expected 0", j, a_rdata); else n_pass++;
            end
            if (j < 6) begin
                n_checks++; if (a_ready !== 4'(1 << (j % NR))) $display("FAIL rr_ready[%0d]: got %b expected %b", j, a_ready, 4'(1 << (j % NR))); else n_pass++;
            end else begin
                a_valid = '0;
            end
            @(negedge clk);
        end
        #1;
        n_checks++; if (a_rsp !== 4'b0) $display("FAIL rr_idle_rsp: got %b expected 0000", a_rsp); else n_pass++;
    endtask

    task automatic test_read_after_clear;
        drive_a(0, 1'b1, '0, 4'd7, '0);
        #1;
        n_checks++; if (a_ready !== 4'b0001) $display("FAIL rd7_ready: got %b expected 0001", a_ready); else n_pass++;
        @(negedge clk);
        a_valid = '0;
        #1;
        n_checks++; if (a_rsp !== 4'b0001 || a_rdata !== '0) $display("FAIL rd7_rsp: got %b/%h expected 0001/0", a_rsp, a_rdata); else n_pass++;
    endtask

    task automatic test_write_read;
        @(negedge clk);
        drive_a(1, 1'b1, 5'h1f, 4'd5, 36'h123456789);
        #1;
        n_checks++; if (a_ready !== 4'b0010) $display("FAIL wr_ready: got %b expected 0010", a_ready); else n_pass++;
        @(negedge clk);
        drive_a(1, 1'b0, '0, '0, '0);
        drive_a(2, 1'b1, '0, 4'd5, '0);
        #1;
        n_checks++; if (a_rsp !== 4'b0) $display("FAIL wr_no_rsp: got %b expected 0000", a_rsp); else n_pass++;
        n_checks++; if (a_ready !== 4'b0100) $display("FAIL rd5_ready: got %b expected 0100", a_ready); else n_pass++;
        @(negedge clk);
        a_valid = '0;
        #1;
        n_checks++; if (a_rsp !== 4'b0100 || a_rdata !== 36'h123456789) $display("FAIL rd5_rsp: got %b/%h expected 0100/123456789", a_rsp, a_rdata); else n_pass++;
    endtask

    task automatic test_byte_enable;
        @(negedge clk);
        drive_a(3, 1'b1, 5'h1f, 4'd9, 36'h0AABBCCDD);
        @(negedge clk);
        drive_a(3, 1'b1, 5'b00010, 4'd9, 36'h011223344);
        @(negedge clk);
        drive_a(3, 1'b1, '0, 4'd9, '0);
        @(negedge clk);
        a_valid = '0;
        #1;
        n_checks++; if (a_rsp !== 4'b1000 || a_rdata !== 36'h0AABB33DD) $display("FAIL be_rsp: got %b/%h expected 1000/0aabb33dd", a_rsp, a_rdata); else n_pass++;
    endtask

    task automatic test_latency2;
        logic [DW-1:0] exp_d [3];
        @(negedge clk);
        b_rst_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j <= 5; j++) begin
            #1;
            if (j >= 2 && j <= 4) begin
                n_checks++; if (b_rsp !== 4'b0001 || b_rdata !== exp_d[j-2]) $display("FAIL lat2_rsp[%0d]: got %b/%h expected 0001/%h", j, b_rsp, b_rdata, exp_d[j-2]); else n_pass++;
            end else begin
                n_checks++; if (b_rsp !== 4'b0) $display("FAIL lat2_idle[%0d]: got %b expected 0000", j, b_rsp); else n_pass++;
            end
            if (j < 3) begin
                drive_b(0, 1'b1, AW'(3 + j));
                exp_d[j] = mem_b[3 + j];
                #1;
                n_checks++; if (b_ready !== 4'b0001) $display("FAIL lat2_ready[%0d]: got %b expected 0001", j, b_ready); else n_pass++;
            end else begin
                b_valid = '0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_inflight;
        drive_b(0, 1'b1, 4'd1);
        @(negedge clk);
        drive_b(0, 1'b0, '0);
        drive_b(1, 1'b1, 4'd2);
        @(posedge clk);
        #1;
        b_rst_n = 1'b0;
        b_valid = '0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 2) b_rst_n = 1'b1;
            #1;
            n_checks++; if (b_rsp !== 4'b0) $display("FAIL inflight_rsp[%0d]: got %b expected 0000", j, b_rsp); else n_pass++;
        end
        b_valid = '1;
        #1;
        n_checks++; if (b_ready !== 4'b0001) $display("FAIL rst_ptr: got %b expected 0001", b_ready); else n_pass++;
        b_valid = '0;
        // reset in the middle of instance A's clear sequence
        @(negedge clk);
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_checks++; if (a_baddr !== 15'd5) $display("FAIL midclr_addr: got %0d expected 5", a_baddr); else n_pass++;
        a_rst_n = 1'b0;
        #1;
        n_checks++; if (a_busy !== 1'b1 || a_en !== 1'b0) $display("FAIL midclr_rst: got %b/%b expected 1/0", a_busy, a_en); else n_pass++;
        @(negedge clk);
        a_rst_n = 1'b1;
        #1;
        n_checks++; if (a_baddr !== 15'd0 || a_busy !== 1'b1) $display("FAIL midclr_restart: got %0d/%b expected 0/1", a_baddr, a_busy); else n_pass++;
    endtask

    task automatic test_random_traffic;
        int   g;
        rsp_t e;
        logic [NR-1:0] exp_rsp;
        logic [DW-1:0] exp_data;
        @(negedge clk);
        a_valid = '0;
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        for (int i = 0; i < NR; i++) pend_v[i] = 1'b0;
        ref_ptr = 0;
        exp_q.delete();
        #1;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL rnd_busy: got %b expected 0", a_busy); else n_pass++;
        for (int c = 0; c < 300; c++) begin
            exp_rsp  = '0;
            exp_data = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                exp_rsp  = e.tag;
                exp_data = e.data;
            end
            n_checks++; if (a_rsp !== exp_rsp) $display("FAIL rnd_rsp[%0d]: got %b expected %b", c, a_rsp, exp_rsp); else n_pass++;
            if (exp_rsp != '0) begin
                n_checks++; if (a_rdata !== exp_data) $display("FAIL rnd_rdata[%0d]: got %h expected %h", c, a_rdata, exp_data); else n_pass++;
            end
            for (int i = 0; i < NR; i++) begin
                if (c < 290 && !pend_v[i] && $urandom_range(0, 2) != 0) begin
                    pend_v[i]    = 1'b1;
                    pend_we[i]   = ($urandom_range(0, 1) == 0) ? '0 : WW'($urandom_range(1, 31));
                    pend_addr[i] = AW'($urandom);
                    pend_data[i] = 36'({$urandom, $urandom});
                end
                drive_a(i, pend_v[i], pend_we[i], pend_addr[i], pend_data[i]);
            end
            #1;
            g = -1;
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && pend_v[(ref_ptr + k) % NR]) g = (ref_ptr + k) % NR;
            end
            n_checks++; if (a_ready !== ((g < 0) ? 4'b0 : 4'(1 << g))) $display("FAIL rnd_ready[%0d]: got %b expected grant %0d", c, a_ready, g); else n_pass++;
            if (g >= 0) begin
                n_checks++; if (a_en !== 1'b1 || a_baddr !== 15'(pend_addr[g]) || a_bwe !== pend_we[g]) $display("FAIL rnd_bram[%0d]: got %b/%0d/%h expected 1/%0d/%h", c, a_en, a_baddr, a_bwe, pend_addr[g], pend_we[g]); else n_pass++;
                if (pend_we[g] == '0) begin
                    e.due  = cyc + 1;
                    e.tag  = 4'(1 << g);
                    e.data = ref_mem[pend_addr[g]];
                    exp_q.push_back(e);
                end else begin
                    ref_mem[pend_addr[g]] = merge(ref_mem[pend_addr[g]], pend_data[g], pend_we[g]);
                end
                ref_ptr   = (g + 1) % NR;
                pend_v[g] = 1'b0;
            end else begin
                n_checks++; if (a_en !== 1'b0) $display("FAIL rnd_idle_en[%0d]: got %b expected 0", c, a_en); else n_pass++;
            end
            @(negedge clk);
        end
        a_valid = '0;
        n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_drain: got %0d outstanding expected 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        a_valid = '0; b_valid = '0;
        test_reset();
        test_clear();
        test_round_robin();
        test_read_after_clear();
        test_write_read();
        test_byte_enable();
        test_latency2();
        test_reset_inflight();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
